// File: rtl/iter_divider_if.sv
// Start/busy/done handshake and operand/result bus of the iterative divider.
// The pipeline side drives the master modport, the divider takes the slave modport.
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic                 div_zero;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start,
        output is_signed,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  div_zero,
        input  result
    );

    modport slave (
        input  start,
        input  is_signed,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output div_zero,
        output result
    );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for div/divu: one quotient bit per RUN cycle,
// sign fix-up in FIX, result published as {remainder, quotient} in DONE.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    iter_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     divisor_mag;
    logic                 quot_neg;
    logic                 rem_neg;
    logic                 zero_div;

    logic                 busy_q;
    logic                 done_q;
    logic                 div_zero_q;
    logic [2*WIDTH-1:0]   result_q;

    logic                 dividend_neg;
    logic                 divisor_neg;
    logic [WIDTH-1:0]     dividend_abs;
    logic [WIDTH-1:0]     divisor_abs;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;

    // Trial subtraction at WIDTH+1 bits: the MSB of trial is the borrow,
    // i.e. set exactly when the shifted remainder is below the divisor.
    always_comb begin
        dividend_neg = bus.is_signed & bus.dividend[WIDTH-1];
        divisor_neg  = bus.is_signed & bus.divisor[WIDTH-1];
        dividend_abs = dividend_neg ? -bus.dividend : bus.dividend;
        divisor_abs  = divisor_neg  ? -bus.divisor  : bus.divisor;
        shifted      = {rem, quot[WIDTH-1]};
        trial        = shifted - {1'b0, divisor_mag};
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // every register (datapath included) is cleared to keep outputs X-free.
    // NOTE: all state here is assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quot        <= '0;
            divisor_mag <= '0;
            quot_neg    <= 1'b0;
            rem_neg     <= 1'b0;
            zero_div    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        count  <= '0;
                        if (bus.divisor == '0) begin
                            // Divide by zero skips iteration entirely.
                            zero_div <= 1'b1;
                            rem      <= bus.dividend;
                            quot     <= '1;
                            quot_neg <= 1'b0;
                            rem_neg  <= 1'b0;
                            state    <= DONE;
                        end else begin
                            zero_div    <= 1'b0;
                            rem         <= '0;
                            quot        <= dividend_abs;
                            divisor_mag <= divisor_abs;
                            quot_neg    <= dividend_neg ^ divisor_neg;
                            rem_neg     <= dividend_neg;
                            state       <= RUN;
                        end
                    end
                end

                RUN: begin
                    count <= count + CW'(1);
                    if (!trial[WIDTH]) begin
                        rem  <= trial[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], 1'b1};
                    end else begin
                        rem  <= shifted[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], 1'b0};
                    end
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (quot_neg) quot <= -quot;
                    if (rem_neg)  rem  <= -rem;
                    state <= DONE;
                end

                DONE: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    div_zero_q <= zero_div;
                    result_q   <= {rem, quot};
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.result   = result_q;
endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: hand-computed quotient/remainder vectors,
// handshake latency, ignored Start pulses and mid-run reset.
module tb_iter_divider;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    iter_divider_if #(.WIDTH(WIDTH)) bus ();

    iter_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one divide and follow it to Done; optionally pulse Start twice
    // with other operands while the divide is running.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_result,
                           input logic exp_dz, input int exp_lat, input bit pulse_extra);
        int lat;
        int extra_dones;
        bit busy_ok;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 32'h0000_0005;
        check({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
        lat     = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (pulse_extra && (lat == 4 || lat == 19)) begin
                bus.start     = 1'b1;
                bus.is_signed = 1'b1;
                bus.dividend  = 32'h0000_0FFF;
                bus.divisor   = 32'h0000_0003;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
            if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_result"}, bus.result, exp_result);
        check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
        extra_dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra_dones++;
        end
        check({tag, "_single_done"}, 64'(extra_dones), 64'd0);
        check({tag, "_result_held"}, bus.result, exp_result);
    endtask

    initial begin
        int dones_after_reset;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_div_zero", 64'(bus.div_zero), 64'd0);
        check("reset_result", bus.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 34, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 34, 1'b0);
        run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0, 34, 1'b0);
        run_div("div_by_zero", 1'b1, 32'h1234_5678, 32'h0, 64'h12345678_FFFFFFFF, 1'b1, 1, 1'b0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, 34, 1'b0);
        run_div("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0, 34, 1'b0);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 64'h00000000_FFFFFFFF, 1'b0, 34, 1'b0);
        run_div("ignore_start", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 34, 1'b1);
        run_div("divu_zero_pre_rst", 1'b0, 32'hCAFE_0001, 32'h0, 64'hCAFE0001_FFFFFFFF, 1'b1, 1, 1'b0);

        // Reset in the middle of a running divide.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_run_busy_before_rst", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_div_zero", 64'(bus.div_zero), 64'd0);
        check("mid_rst_result", bus.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones_after_reset = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones_after_reset++;
        end
        check("mid_rst_no_done", 64'(dones_after_reset), 64'd0);

        run_div("divu_after_rst", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 1'b0, 34, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
